// File: rtl/quadrature_pkg.sv
// Shared decode definitions for the multi-channel quadrature decoder.
//   step_t      : per-cycle step classification of a filtered {A,B} change
//   gray_pos    : position (0..3) of an {A,B} level within the forward cycle
//   decode_step : maps {previous, new} filtered {A,B} to a step
package quadrature_pkg;

    // Encoded so that the value equals (new position - old position) mod 4.
    typedef enum logic [1:0] {
        STEP_NONE    = 2'd0,
        STEP_UP      = 2'd1,
        STEP_ILLEGAL = 2'd2,
        STEP_DN      = 2'd3
    } step_t;

    // Forward cycle 00 -> 10 -> 11 -> 01 maps to positions 0,1,2,3 ({A,B}).
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    function automatic step_t decode_step(input logic [1:0] prev_ab,
                                          input logic [1:0] new_ab);
        logic [1:0] diff;
        diff = gray_pos(new_ab) - gray_pos(prev_ab);
        return step_t'(diff);
    endfunction

endpackage

// File: rtl/quadrature_multi_if.sv
// Pin/bus bundle of the multi-channel quadrature decoder.
//   inputs to decoder : quadA, quadB, idx (raw, async), idx_en, clr, clr_err, latch
//   outputs           : count, count_latched (channel n at [n*CNT_W +: CNT_W]), dir, err
interface quadrature_multi_if #(
    parameter int unsigned NCH   = 2,
    parameter int unsigned CNT_W = 32
);
    logic [NCH-1:0]       quadA;
    logic [NCH-1:0]       quadB;
    logic [NCH-1:0]       idx;
    logic [NCH-1:0]       idx_en;
    logic [NCH-1:0]       clr;
    logic                 clr_err;
    logic                 latch;
    logic [NCH*CNT_W-1:0] count;
    logic [NCH*CNT_W-1:0] count_latched;
    logic [NCH-1:0]       dir;
    logic [NCH-1:0]       err;

    modport master (
        output quadA, quadB, idx, idx_en, clr, clr_err, latch,
        input  count, count_latched, dir, err
    );

    modport slave (
        input  quadA, quadB, idx, idx_en, clr, clr_err, latch,
        output count, count_latched, dir, err
    );
endinterface

// File: rtl/quad_channel.sv
// One quadrature channel: synchroniser, glitch filter, priming, decode,
// index zeroing, wrap/saturate counter and sticky illegal-transition flag.
//   clk, rst           : clock, synchronous active-high reset
//   a_in, b_in, idx_in : raw asynchronous encoder inputs
//   idx_en, clr        : zero-on-index enable, synchronous count clear
//   clr_err            : clears err (a coincident illegal step wins)
//   count, dir, err    : registered signed count, last direction, sticky error
module quad_channel
    import quadrature_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter bit          WRAP        = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             idx_in,
    input  logic             idx_en,
    input  logic             clr,
    input  logic             clr_err,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             err
);
    localparam int unsigned FCW    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int unsigned FILL_W = $clog2(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MIN = {1'b1, {(CNT_W-1){1'b0}}};

    // Bit order for all 3-bit vectors: [0]=A, [1]=B, [2]=idx.
    logic [2:0]                  raw;
    logic [2:0][SYNC_STAGES-1:0] sync_q;
    logic [2:0]                  sync_out;
    logic [2:0]                  cur;
    logic [2:0]                  prev_q;
    logic [FILL_W-1:0]           fill_q;
    logic                        primed_q;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        dir_q, dir_d, err_q, err_d;
    step_t                       step;
    logic                        idx_rise;

    assign raw = {idx_in, b_in, a_in};

    // Synchroniser chains and priming: wait until the chains hold real samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            fill_q   <= '0;
            primed_q <= 1'b0;
            prev_q   <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            end
            if (!primed_q) begin
                if (fill_q == FILL_W'(SYNC_STAGES)) begin
                    primed_q <= 1'b1;
                    prev_q   <= sync_out;
                end else begin
                    fill_q <= fill_q + FILL_W'(1);
                end
            end else begin
                prev_q <= cur;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            sync_out[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Glitch filter: a new level must persist FILT_LEN cycles to be accepted.
    generate
        if (FILT_LEN == 0) begin : g_nofilt
            assign cur = sync_out;
        end else begin : g_filt
            logic [2:0]          filt_q;
            logic [2:0][FCW-1:0] hold_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    filt_q <= '0;
                    hold_q <= '0;
                end else if (!primed_q) begin
                    filt_q <= sync_out;
                    hold_q <= '0;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (sync_out[i] == filt_q[i]) begin
                            hold_q[i] <= '0;
                        end else if (hold_q[i] == FCW'(FILT_LEN - 1)) begin
                            filt_q[i] <= sync_out[i];
                            hold_q[i] <= '0;
                        end else begin
                            hold_q[i] <= hold_q[i] + FCW'(1);
                        end
                    end
                end
            end
            assign cur = filt_q;
        end
    endgenerate

    assign step     = decode_step({prev_q[0], prev_q[1]}, {cur[0], cur[1]});
    assign idx_rise = cur[2] & ~prev_q[2] & idx_en;

    // Counter next state; priority clr > index zero > step.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        err_d   = err_q;
        if (clr_err) begin
            err_d = 1'b0;
        end
        if (primed_q) begin
            case (step)
                STEP_UP: begin
                    dir_d   = 1'b1;
                    count_d = (count_q == CNT_MAX) ? (WRAP ? CNT_MIN : CNT_MAX)
                                                   : count_q + CNT_W'(1);
                end
                STEP_DN: begin
                    dir_d   = 1'b0;
                    count_d = (count_q == CNT_MIN) ? (WRAP ? CNT_MAX : CNT_MIN)
                                                   : count_q - CNT_W'(1);
                end
                STEP_ILLEGAL: err_d = 1'b1;
                default: ;
            endcase
            if (idx_rise) begin
                count_d = '0;
            end
        end
        if (clr) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign err   = err_q;
endmodule

// File: rtl/quadrature_multi.sv
// Multi-channel quadrature decoder: NCH independent channels plus an atomic
// snapshot of all counts taken on latch (captures the pre-update counts).
//   clk, rst : clock, synchronous active-high reset
//   bus      : quadrature_multi_if slave (raw pins, controls, counts, flags)
module quadrature_multi #(
    parameter int unsigned NCH         = 2,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter bit          WRAP        = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    quadrature_multi_if.slave    bus
);
    logic [NCH*CNT_W-1:0] count_w;
    logic [NCH*CNT_W-1:0] latched_q;
    logic [NCH-1:0]       dir_w;
    logic [NCH-1:0]       err_w;

    generate
        for (genvar n = 0; n < NCH; n++) begin : g_ch
            quad_channel #(
                .CNT_W      (CNT_W),
                .SYNC_STAGES(SYNC_STAGES),
                .FILT_LEN   (FILT_LEN),
                .WRAP       (WRAP)
            ) u_ch (
                .clk    (clk),
                .rst    (rst),
                .a_in   (bus.quadA[n]),
                .b_in   (bus.quadB[n]),
                .idx_in (bus.idx[n]),
                .idx_en (bus.idx_en[n]),
                .clr    (bus.clr[n]),
                .clr_err(bus.clr_err),
                .count  (count_w[n*CNT_W +: CNT_W]),
                .dir    (dir_w[n]),
                .err    (err_w[n])
            );
        end
    endgenerate

    // Snapshot of all channels in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            latched_q <= '0;
        end else if (bus.latch) begin
            latched_q <= count_w;
        end
    end

    assign bus.count         = count_w;
    assign bus.count_latched = latched_q;
    assign bus.dir           = dir_w;
    assign bus.err           = err_w;
endmodule

// File: tb/tb_quadrature_multi.sv
// Directed self-checking bench for quadrature_multi: a 32-bit wrapping
// instance carries the functional tests, two 8-bit instances (wrap and
// saturate) share the same pin drive for the limit tests.
module tb_quadrature_multi;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] qa = '0, qb = '0, qi = '0, ien = '0, qclr = '0;
    logic       clr_err = 1'b0;
    logic       latch = 1'b0;
    logic [1:0] pos [2];
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    quadrature_multi_if #(.NCH(2), .CNT_W(32)) if_d ();
    quadrature_multi_if #(.NCH(2), .CNT_W(8))  if_w ();
    quadrature_multi_if #(.NCH(2), .CNT_W(8))  if_s ();

    assign if_d.quadA = qa;   assign if_w.quadA = qa;   assign if_s.quadA = qa;
    assign if_d.quadB = qb;   assign if_w.quadB = qb;   assign if_s.quadB = qb;
    assign if_d.idx = qi;     assign if_w.idx = qi;     assign if_s.idx = qi;
    assign if_d.idx_en = ien; assign if_w.idx_en = ien; assign if_s.idx_en = ien;
    assign if_d.clr = qclr;   assign if_w.clr = qclr;   assign if_s.clr = qclr;
    assign if_d.clr_err = clr_err; assign if_w.clr_err = clr_err; assign if_s.clr_err = clr_err;
    assign if_d.latch = latch;     assign if_w.latch = latch;     assign if_s.latch = latch;

    quadrature_multi #(.NCH(2), .CNT_W(32), .SYNC_STAGES(2), .FILT_LEN(4), .WRAP(1'b1))
        dut_d (.clk(clk), .rst(rst), .bus(if_d));
    quadrature_multi #(.NCH(2), .CNT_W(8), .SYNC_STAGES(2), .FILT_LEN(4), .WRAP(1'b1))
        dut_w (.clk(clk), .rst(rst), .bus(if_w));
    quadrature_multi #(.NCH(2), .CNT_W(8), .SYNC_STAGES(2), .FILT_LEN(4), .WRAP(1'b0))
        dut_s (.clk(clk), .rst(rst), .bus(if_s));

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Move channel ch one position along the gray cycle and hold it.
    task automatic step(input int ch, input bit up, input int hold);
        pos[ch] = pos[ch] + (up ? 2'd1 : 2'd3);
        qa[ch]  = pos[ch][1] ^ pos[ch][0];
        qb[ch]  = pos[ch][1];
        tick(hold);
    endtask

    function automatic longint d_cnt(input int ch);
        return longint'($signed(if_d.count[ch*32 +: 32]));
    endfunction
    function automatic longint d_lat(input int ch);
        return longint'($signed(if_d.count_latched[ch*32 +: 32]));
    endfunction
    function automatic longint w_cnt();
        return longint'($signed(if_w.count[7:0]));
    endfunction
    function automatic longint s_cnt();
        return longint'($signed(if_s.count[7:0]));
    endfunction

    initial begin
        pos[0] = 2'd2; pos[1] = 2'd2;
        qa = 2'b01; qb = 2'b01;
        tick(3);
        check("rst_count0", d_cnt(0), 0);
        check("rst_count1", d_cnt(1), 0);
        check("rst_latched0", d_lat(0), 0);
        check("rst_dir", longint'(if_d.dir), 0);
        check("rst_err", longint'(if_d.err), 0);

        // Prime at 11 on ch0: no count, no error.
        rst = 1'b0;
        tick(20);
        check("prime_count0", d_cnt(0), 0);
        check("prime_err0", longint'(if_d.err[0]), 0);

        // Restart from 00 on both channels.
        rst = 1'b1; qa = '0; qb = '0; pos[0] = '0; pos[1] = '0;
        tick(2);
        rst = 1'b0;
        tick(20);

        // Latency: first step lands on the 7th edge after drive.
        step(0, 1'b1, 6);
        check("latency_before", d_cnt(0), 0);
        tick(1);
        check("latency_at", d_cnt(0), 1);
        tick(3);
        repeat (3) step(0, 1'b1, 10);
        check("fwd_count0", d_cnt(0), 4);
        check("fwd_dir0", longint'(if_d.dir[0]), 1);
        repeat (4) step(0, 1'b0, 10);
        check("rev_count0", d_cnt(0), 0);
        check("rev_dir0", longint'(if_d.dir[0]), 0);

        // Glitch shorter than the filter length.
        qa[1] = 1'b1; tick(2); qa[1] = 1'b0; tick(10);
        check("glitch_count1", d_cnt(1), 0);
        check("glitch_err1", longint'(if_d.err[1]), 0);

        // Illegal 00 -> 11 on ch1.
        qa[1] = 1'b1; qb[1] = 1'b1; pos[1] = 2'd2;
        tick(10);
        check("illegal_err1", longint'(if_d.err[1]), 1);
        check("illegal_count1", d_cnt(1), 0);
        clr_err = 1'b1; tick(1); clr_err = 1'b0; tick(1);
        check("clr_err1", longint'(if_d.err[1]), 0);
        repeat (3) step(1, 1'b0, 10);
        check("ch1_minus3", d_cnt(1), -3);

        // Index zeroing.
        repeat (37) step(0, 1'b1, 10);
        check("count0_37", d_cnt(0), 37);
        qi[0] = 1'b1; tick(10); qi[0] = 1'b0; tick(10);
        check("idx_disabled", d_cnt(0), 37);
        ien[0] = 1'b1;
        qi[0] = 1'b1; tick(10);
        check("idx_zero", d_cnt(0), 0);
        qi[0] = 1'b0; tick(10);
        repeat (3) step(0, 1'b1, 10);
        check("post_idx_count", d_cnt(0), 3);
        qi[0] = 1'b1;
        step(0, 1'b1, 10);
        check("idx_with_step", d_cnt(0), 0);
        qi[0] = 1'b0; ien[0] = 1'b0; tick(10);

        // Snapshot on the same edge a step lands.
        repeat (5) step(0, 1'b1, 10);
        step(0, 1'b1, 6);
        latch = 1'b1; tick(1); latch = 1'b0;
        check("snap_ch0", d_lat(0), 5);
        check("snap_ch1", d_lat(1), -3);
        check("snap_live0", d_cnt(0), 6);
        tick(4);

        // clr zeroes counts but leaves err alone.
        pos[0] = pos[0] + 2'd2;
        qa[0] = pos[0][1] ^ pos[0][0]; qb[0] = pos[0][1];
        tick(10);
        check("illegal_err0", longint'(if_d.err[0]), 1);
        qclr = 2'b11; tick(1); qclr = '0;
        check("clr_count0", d_cnt(0), 0);
        check("clr_count1", d_cnt(1), 0);
        check("clr_keeps_err0", longint'(if_d.err[0]), 1);

        // clr_err coinciding with a new illegal step: set wins.
        clr_err = 1'b1; tick(2);
        check("clr_err_held", longint'(if_d.err[0]), 0);
        pos[0] = pos[0] + 2'd2;
        qa[0] = pos[0][1] ^ pos[0][0]; qb[0] = pos[0][1];
        tick(7);
        check("set_wins", longint'(if_d.err[0]), 1);
        tick(1);
        clr_err = 1'b0;
        tick(3);

        // Limits on the 8-bit instances.
        qclr = 2'b11; tick(1); qclr = '0;
        repeat (127) step(0, 1'b1, 8);
        check("wrap_at_max", w_cnt(), 127);
        check("sat_at_max", s_cnt(), 127);
        step(0, 1'b1, 8);
        check("wrap_over", w_cnt(), -128);
        check("sat_over", s_cnt(), 127);
        check("sat_no_err", longint'(if_s.err[0]), 0);
        qclr = 2'b11; tick(1); qclr = '0;
        repeat (129) step(0, 1'b0, 8);
        check("wrap_under", w_cnt(), 127);
        check("sat_under", s_cnt(), -128);
        check("wide_count", d_cnt(0), -129);

        // Reset mid-operation, then re-prime at a nonzero level.
        rst = 1'b1; tick(1);
        check("midrst_count0", d_cnt(0), 0);
        check("midrst_latched1", d_lat(1), 0);
        rst = 1'b0; tick(20);
        check("reprime_count0", d_cnt(0), 0);
        check("reprime_err0", longint'(if_d.err[0]), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/quadrature_multi.md
Name: quadrature_multi

Overview:
Parametrised multi-channel quadrature decoder; successor to the single-channel 32-bit x4 decoder.
- Adds per-channel input synchronisation and glitch filtering.
- Adds index-pulse zeroing, illegal-transition detection, wrap/saturate mode, and an atomic all-channel snapshot.
- Sits between the encoder input pins and the control/bus-read logic; one instance serves all motor axes.

Parameters:
NCH, 2, number of encoder channels (1..8)
CNT_W, 32, signed count width per channel (8..32)
SYNC_STAGES, 2, synchroniser flops per input (2..4)
FILT_LEN, 4, consecutive identical samples required to accept a new A/B/idx level (0 = filter bypass)
WRAP, 1, 1 = two's-complement wrap at limits; 0 = saturate at signed min/max

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
quadA  in  NCH  raw encoder A, asynchronous
quadB  in  NCH  raw encoder B, asynchronous
idx  in  NCH  raw index pulse, asynchronous
idx_en  in  NCH  per-channel enable for zero-on-index
clr  in  NCH  per-channel synchronous count clear
clr_err  in  1  clears all err flags
latch  in  1  snapshot strobe
count  out  NCH*CNT_W  live signed counts, channel n at [n*CNT_W +: CNT_W]
count_latched  out  NCH*CNT_W  snapshot registers, same packing
dir  out  NCH  direction of last valid step (1 = up)
err  out  NCH  sticky illegal-transition flag

Behaviour:
- Reset (rst=1 at an edge):
  - count, count_latched, dir and err are 0.
  - Per-channel primed flag is cleared.
  - Filter counters are cleared.
- Synchroniser: SYNC_STAGES flops per A, B and idx; each channel is independent.
- Filter:
  - A level is accepted once the synchronised value differs from the filtered value and holds for FILT_LEN consecutive cycles.
  - A bounce resets the hold counter.
  - FILT_LEN=0 passes the synchronised value straight through.
- Priming:
  - The first cycle after rst deasserts with a synchronised sample available, the filtered {A,B} loads from it without counting.
  - No count pulse is generated from the reset state.
- Decode: compare previous filtered {A,B} with new filtered {A,B}.
  - 00->10, 10->11, 11->01, 01->00: +1, dir<=1.
  - Reverse sequence: -1, dir<=0.
  - No change: hold.
  - Both bits change in one cycle (00<->11, 01<->10): no count change, dir held, err<=1.
- Latency: a clean edge on quadA that is stable from cycle 0 updates count at cycle SYNC_STAGES+FILT_LEN+1.
- Index:
  - Rising edge of filtered idx with idx_en=1 sets count<=0 in the same cycle the edge is detected.
  - idx_en=0 ignores idx.
- Priority per channel: rst > clr > index zero > step.
  - Simultaneous index and step: result is 0.
  - clr does not affect err.
- Limits:
  - WRAP=1: max+1 -> min, min-1 -> max.
  - WRAP=0: hold at max/min; does not set err.
- Snapshot:
  - latch=1 copies every channel's count into count_latched on the same edge.
  - The copied value is the count before that edge's update.
  - All channels are captured atomically.
- err: sticky until clr_err or rst. If clr_err coincides with a new illegal transition, err=1 (set wins).
- Reset mid-operation: counts zero immediately and channels re-prime; in-flight filter state is discarded.

Decomposition:
- Package quadrature_pkg holds:
  - Step encoding constants (STEP_NONE, STEP_UP, STEP_DN, STEP_ILLEGAL).
  - A decode function mapping {prev, new} -> step.
- Sub-module quad_channel holds per-channel sync, filter, prime, decode, counter and err logic.
- quadrature_multi generates NCH instances and owns the shared latch/snapshot registers.

Test Plan:
- Prime: rst, hold ch0 A=1,B=1, release -> count0 stays 0 after 20 cycles, err0=0.
- Forward 4x: ch0 drives 00,10,11,01,00 with each level held 10 cycles (FILT_LEN=4) -> count0=4, dir0=1; reverse the sequence -> count0=0, dir0=0.
- Glitch: 2-cycle pulse on A1 with FILT_LEN=4 -> count1 unchanged. Illegal 00->11 jump on ch1 -> err1=1, count1 unchanged; clr_err -> err1=0.
- Index: count0=37, idx_en0=1, idx pulse held 10 cycles -> count0=0. Same pulse with idx_en0=0 -> count0 stays 37. Index coinciding with a step -> 0.
- Limits, CNT_W=8: WRAP=1 at 127 plus one step -> -128. WRAP=0 at 127 plus one step -> 127.
- Snapshot: ch0=5, ch1=-3, latch pulsed on the same cycle a step reaches ch0 -> count_latched = {-3, 5}, count0=6 afterwards.
